// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch request/response sequencer with redirect handling
// Optional response watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic       fetch_clock_in,
    input  logic       fetch_reset_in,
    input  logic       fetch_run_in,
    input  logic       fetch_offset_flag_in,
    input  logic       fetch_target_flag_in,
    input  logic       fetch_prediction_flag_in,
    input  logic       fetch_ins_mem_ready_in,
    input  logic       fetch_ins_mem_rsp_valid_in,
    input  logic       fetch_dec_stall_in,
    output logic       fetch_ins_mem_valid_out,
    output logic       fetch_pc_set_out,
    output logic [1:0] fetch_pc_sel_out,
    output logic       fetch_if_dec_set_out,
    output logic       fetch_if_dec_flush_out,
    output logic [1:0] fetch_state_out,
    output logic       fetch_timeout_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQUEST = 2'b01,
        S_WAIT    = 2'b10,
        S_HOLD    = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_pend_vld;
    logic [1:0] r_pend_sel;
    logic       r_pc_set;
    logic [1:0] r_pc_sel;
    logic       r_if_dec_set;
    logic       r_flush;

    logic       w_flag_any;
    logic [1:0] w_flag_sel;
    logic       w_active;
    logic       w_pend_vld;
    logic [1:0] w_pend_sel;
    logic       w_pend_clr;
    logic       w_pc_set_nxt;
    logic [1:0] w_pc_sel_nxt;
    logic       w_if_dec_set_nxt;
    logic       w_flush_nxt;
    logic       w_timeout_hit;

    // A flag arriving this cycle overrides any older pending redirect.
    assign w_flag_any = fetch_target_flag_in | fetch_offset_flag_in | fetch_prediction_flag_in;
    assign w_flag_sel = fetch_target_flag_in ? 2'b10 :
                        fetch_offset_flag_in ? 2'b01 : 2'b11;
    assign w_active   = (r_state != S_IDLE);
    assign w_pend_vld = r_pend_vld | w_flag_any;
    assign w_pend_sel = w_flag_any ? w_flag_sel : r_pend_sel;

    always_comb begin
        w_state_next     = r_state;
        w_pend_clr       = 1'b0;
        w_pc_set_nxt     = 1'b0;
        w_pc_sel_nxt     = 2'b00;
        w_if_dec_set_nxt = 1'b0;
        w_flush_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fetch_run_in) w_state_next = S_REQUEST;
            end
            S_REQUEST: begin
                if (fetch_ins_mem_ready_in) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (fetch_ins_mem_rsp_valid_in) begin
                    if (w_pend_vld) begin
                        w_flush_nxt  = 1'b1;
                        w_pc_set_nxt = 1'b1;
                        w_pc_sel_nxt = w_pend_sel;
                        w_pend_clr   = 1'b1;
                        w_state_next = fetch_run_in ? S_REQUEST : S_IDLE;
                    end else if (fetch_dec_stall_in) begin
                        w_state_next = S_HOLD;
                    end else begin
                        w_if_dec_set_nxt = 1'b1;
                        w_pc_set_nxt     = 1'b1;
                        w_state_next     = fetch_run_in ? S_REQUEST : S_IDLE;
                    end
                end else if (w_timeout_hit) begin
                    w_state_next = S_REQUEST;
                end
            end
            S_HOLD: begin
                if (w_pend_vld) begin
                    w_flush_nxt  = 1'b1;
                    w_pc_set_nxt = 1'b1;
                    w_pc_sel_nxt = w_pend_sel;
                    w_pend_clr   = 1'b1;
                    w_state_next = fetch_run_in ? S_REQUEST : S_IDLE;
                end else if (!fetch_dec_stall_in) begin
                    w_if_dec_set_nxt = 1'b1;
                    w_pc_set_nxt     = 1'b1;
                    w_state_next     = fetch_run_in ? S_REQUEST : S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge fetch_clock_in or negedge fetch_reset_in) begin
        if (!fetch_reset_in) begin
            r_state      <= S_IDLE;
            r_pend_vld   <= 1'b0;
            r_pend_sel   <= 2'b00;
            r_pc_set     <= 1'b0;
            r_pc_sel     <= 2'b00;
            r_if_dec_set <= 1'b0;
            r_flush      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc_set     <= w_pc_set_nxt;
            r_pc_sel     <= w_pc_sel_nxt;
            r_if_dec_set <= w_if_dec_set_nxt;
            r_flush      <= w_flush_nxt;
            if (w_pend_clr) begin
                r_pend_vld <= 1'b0;
                r_pend_sel <= 2'b00;
            end else if (w_flag_any && w_active) begin
                r_pend_vld <= 1'b1;
                r_pend_sel <= w_flag_sel;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_wd_cnt;
    logic [TIMEOUT_W-1:0] w_wd_cnt_nxt;
    logic                 r_timeout;

    // Fires on the WAIT cycle whose increment would reach all-ones.
    assign w_wd_cnt_nxt  = r_wd_cnt + 1'b1;
    assign w_timeout_hit = (r_state == S_WAIT) && !fetch_ins_mem_rsp_valid_in
                           && (w_wd_cnt_nxt == {TIMEOUT_W{1'b1}});

    always_ff @(posedge fetch_clock_in or negedge fetch_reset_in) begin
        if (!fetch_reset_in) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == S_WAIT) && !fetch_ins_mem_rsp_valid_in && !w_timeout_hit)
                r_wd_cnt <= w_wd_cnt_nxt;
            else
                r_wd_cnt <= '0;
            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end

    assign fetch_timeout_out = r_timeout;
`else
    // Watchdog absent: a zero width is the only way it could ever fire.
    assign w_timeout_hit     = (TIMEOUT_W == 0);
    assign fetch_timeout_out = 1'b0;
`endif

    assign fetch_ins_mem_valid_out = (r_state == S_REQUEST);
    assign fetch_pc_set_out        = r_pc_set;
    assign fetch_pc_sel_out        = r_pc_sel;
    assign fetch_if_dec_set_out    = r_if_dec_set;
    assign fetch_if_dec_flush_out  = r_flush;
    assign fetch_state_out         = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam logic [1:0] ST_IDLE = 2'b00, ST_REQ = 2'b01, ST_WAIT = 2'b10, ST_HOLD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, off_f, tgt_f, pred_f, ready, rsp, stall;
    logic       valid_o, pc_set_o, dec_set_o, flush_o, timeout_o;
    logic [1:0] pc_sel_o, state_o;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];

    fetch_sequencer #(.TIMEOUT_W(4)) dut (
        .fetch_clock_in            (clk),
        .fetch_reset_in            (rst_n),
        .fetch_run_in              (run),
        .fetch_offset_flag_in      (off_f),
        .fetch_target_flag_in      (tgt_f),
        .fetch_prediction_flag_in  (pred_f),
        .fetch_ins_mem_ready_in    (ready),
        .fetch_ins_mem_rsp_valid_in(rsp),
        .fetch_dec_stall_in        (stall),
        .fetch_ins_mem_valid_out   (valid_o),
        .fetch_pc_set_out          (pc_set_o),
        .fetch_pc_sel_out          (pc_sel_o),
        .fetch_if_dec_set_out      (dec_set_o),
        .fetch_if_dec_flush_out    (flush_o),
        .fetch_state_out           (state_o),
        .fetch_timeout_out         (timeout_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every pc_set pulse must match the next expected {set, flush, sel}.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pc_set_o === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse set=%b flush=%b sel=%b, none expected", dec_set_o, flush_o, pc_sel_o);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    if ({dec_set_o, flush_o, pc_sel_o} !== e) begin
                        fails++;
                        $display("FAIL pulse got {set,flush,sel}=%b expected %b", {dec_set_o, flush_o, pc_sel_o}, e);
                    end
                end
            end else begin
                tests++;
                if ({dec_set_o, flush_o, pc_sel_o} !== 4'b0000) begin
                    fails++;
                    $display("FAIL quiet_outputs got {set,flush,sel}=%b expected 0000", {dec_set_o, flush_o, pc_sel_o});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input logic [1:0] exp, input string name);
        tests++;
        if (state_o !== exp || valid_o !== (exp == ST_REQ)) begin
            fails++;
            $display("FAIL %s state=%b valid=%b expected state=%b valid=%b", name, state_o, valid_o, exp, (exp == ST_REQ));
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string name);
        int n;
        n = 0;
        while (state_o !== s && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (state_o !== s) begin
            fails++;
            $display("FAIL %s_timeout state=%b expected %b", name, state_o, s);
        end
    endtask

    task automatic go_wait(input string name);
        run = 1'b1;
        wait_state(ST_REQ, name);
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_state(ST_WAIT, name);
    endtask

    task automatic check_all_zero(input string name);
        tests++;
        if ({valid_o, pc_set_o, pc_sel_o, dec_set_o, flush_o, state_o, timeout_o} !== 9'b0) begin
            fails++;
            $display("FAIL %s outputs=%b expected all zero",
                     name, {valid_o, pc_set_o, pc_sel_o, dec_set_o, flush_o, state_o, timeout_o});
        end
    endtask

    task automatic test_reset();
        #3;
        check_all_zero("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check_state(ST_IDLE, "reset_idle");
    endtask

    task automatic test_basic();
        run = 1'b1;
        step();
        check_state(ST_REQ, "basic_c1");
        step();
        check_state(ST_REQ, "basic_c2");
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_state(ST_WAIT, "basic_c3");
        step();
        rsp = 1'b1;
        exp_q.push_back(4'b1000);
        step();
        rsp = 1'b0;
        check_state(ST_REQ, "basic_c5");
    endtask

    task automatic test_hold();
        go_wait("hold_enter");
        stall = 1'b1;
        rsp = 1'b1;
        step();
        rsp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_state(ST_HOLD, "hold_persist");
            if (i < 2) step();
        end
        stall = 1'b0;
        exp_q.push_back(4'b1000);
        step();
        check_state(ST_REQ, "hold_release");
    endtask

    task automatic test_redirect_wait();
        go_wait("rdw_enter");
        tgt_f = 1'b1;
        pred_f = 1'b1;
        step();
        tgt_f = 1'b0;
        pred_f = 1'b0;
        check_state(ST_WAIT, "rdw_wait");
        rsp = 1'b1;
        exp_q.push_back(4'b0110);
        step();
        rsp = 1'b0;
        check_state(ST_REQ, "rdw_after");
    endtask

    task automatic test_redirect_hold();
        go_wait("rdh_enter");
        stall = 1'b1;
        rsp = 1'b1;
        step();
        rsp = 1'b0;
        check_state(ST_HOLD, "rdh_hold");
        off_f = 1'b1;
        exp_q.push_back(4'b0101);
        step();
        off_f = 1'b0;
        stall = 1'b0;
        check_state(ST_REQ, "rdh_after");
    endtask

    task automatic test_flag_with_rsp();
        go_wait("fwr_enter");
        pred_f = 1'b1;
        rsp = 1'b1;
        exp_q.push_back(4'b0111);
        step();
        pred_f = 1'b0;
        rsp = 1'b0;
        check_state(ST_REQ, "fwr_after");
    endtask

    task automatic test_overwrite_in_request();
        wait_state(ST_REQ, "ovr_req");
        off_f = 1'b1;
        step();
        off_f = 1'b0;
        check_state(ST_REQ, "ovr_no_abort");
        ready = 1'b1;
        step();
        ready = 1'b0;
        check_state(ST_WAIT, "ovr_wait");
        tgt_f = 1'b1;
        step();
        tgt_f = 1'b0;
        stall = 1'b1;
        rsp = 1'b1;
        exp_q.push_back(4'b0110);
        step();
        rsp = 1'b0;
        stall = 1'b0;
        check_state(ST_REQ, "ovr_after");
    endtask

    task automatic test_run_drop();
        go_wait("drop_enter");
        run = 1'b0;
        step();
        check_state(ST_WAIT, "drop_still_wait");
        rsp = 1'b1;
        exp_q.push_back(4'b1000);
        step();
        rsp = 1'b0;
        check_state(ST_IDLE, "drop_idle");
    endtask

    task automatic test_idle_flags();
        off_f = 1'b1;
        tgt_f = 1'b1;
        step();
        off_f = 1'b0;
        tgt_f = 1'b0;
        pred_f = 1'b1;
        step();
        pred_f = 1'b0;
        check_state(ST_IDLE, "idle_flags");
        go_wait("idle_flags_enter");
        rsp = 1'b1;
        exp_q.push_back(4'b1000);
        step();
        rsp = 1'b0;
        check_state(ST_REQ, "idle_flags_after");
    endtask

    task automatic test_timeout();
        go_wait("to_enter");
`ifdef FETCH_TIMEOUT_EN
        repeat (14) step();
        check_state(ST_WAIT, "to_wait15");
        step();
        check_state(ST_REQ, "to_reissue");
        tests++;
        if (timeout_o !== 1'b1) begin
            fails++;
            $display("FAIL to_flag got %b expected 1", timeout_o);
        end
        go_wait("to_reenter");
        rsp = 1'b1;
        exp_q.push_back(4'b1000);
        step();
        rsp = 1'b0;
        tests++;
        if (timeout_o !== 1'b1) begin
            fails++;
            $display("FAIL to_sticky got %b expected 1", timeout_o);
        end
`else
        repeat (30) step();
        check_state(ST_WAIT, "to_wait_forever");
        tests++;
        if (timeout_o !== 1'b0) begin
            fails++;
            $display("FAIL to_tied got %b expected 0", timeout_o);
        end
        rsp = 1'b1;
        exp_q.push_back(4'b1000);
        step();
        rsp = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        go_wait("rst_enter");
        run = 1'b0;
        rsp = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        rsp = 1'b0;
        check_state(ST_IDLE, "rst_release");
    endtask

    initial begin
        rst_n = 1'b0;
        {run, off_f, tgt_f, pred_f, ready, rsp, stall} = '0;
        test_reset();
        test_basic();
        test_hold();
        test_redirect_wait();
        test_redirect_hold();
        test_flag_with_rsp();
        test_overwrite_in_request();
        test_run_drop();
        test_idle_flags();
        test_timeout();
        test_reset_mid();
        step();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses got %0d outstanding expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
